// File: rtl/multi_sync_rx_pkg.sv
// Shared constants and helpers for the multi-channel toggle receiver (multi_sync_rx_ack).
// Optional feature macro used by this family: MULTI_SYNC_RX_OVF_EN.
package multi_sync_rx_pkg;

  localparam int MIN_SYNC_STAGES = 32'sd2;
  localparam int ACK_LATE        = 32'sd0;
  localparam int ACK_EARLY       = 32'sd1;

  // Width that can hold the warm-up terminal count (stages + 1).
  function automatic int warm_cnt_width(input int stages);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < (stages + 32'sd2)) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

  // Effective synchroniser depth, never below the metastability minimum.
  function automatic int eff_sync_stages(input int stages);
    return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
  endfunction

endpackage

// File: rtl/multi_sync_rx_chan.sv
// One receive channel: toggle synchroniser, edge detect, pending counter, deferral and ack.
// Overflow flag storage is present only when MULTI_SYNC_RX_OVF_EN is defined.
module multi_sync_rx_chan
  import multi_sync_rx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 2,
  parameter int ACK_ON_ACCEPT = 0
) (
  input  logic clk_b,
  input  logic b_reset_in,
  input  logic warm_done,
  input  logic tgl,
  input  logic rdy,
  input  logic ovf_clr,
  output logic ack_tgl,
  output logic vld,
  output logic ovf
);

  localparam int STAGES = eff_sync_stages(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [STAGES-1:0] sync_r;
  logic              ref_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              def_r;
  logic              ack_r;
  logic              vld_r;

  logic              ev_s;
  logic              cons_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              def_nxt_s;
  logic              ack_flip_s;
  logic              drop_s;

  // Next-state rules: count, defer (early ack only), drop, and when the ack flips.
  always_comb begin
    ev_s       = warm_done & (sync_r[STAGES-1] ^ ref_r);
    cons_s     = vld_r & rdy;
    cnt_nxt_s  = cnt_r;
    def_nxt_s  = def_r;
    ack_flip_s = 1'b0;
    drop_s     = 1'b0;
    if (ACK_ON_ACCEPT == ACK_EARLY) begin
      if (def_r) begin
        drop_s = ev_s;
        if (cons_s) begin
          def_nxt_s  = 1'b0;
          ack_flip_s = 1'b1;
        end else begin
          def_nxt_s  = 1'b1;
        end
      end else if (ev_s && !cons_s && (cnt_r == CNT_MAX)) begin
        def_nxt_s = 1'b1;
      end else begin
        ack_flip_s = ev_s;
        cnt_nxt_s  = cnt_r + CNT_W'(ev_s) - CNT_W'(cons_s);
      end
    end else begin
      ack_flip_s = cons_s;
      if (ev_s && !cons_s && (cnt_r == CNT_MAX)) begin
        drop_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(ev_s) - CNT_W'(cons_s);
      end
    end
  end

  // Channel state; the edge reference follows the last sync stage even during warm-up.
  always_ff @(posedge clk_b or negedge b_reset_in) begin
    if (!b_reset_in) begin
      sync_r <= {STAGES{1'b0}};
      ref_r  <= 1'b0;
      cnt_r  <= CNT_ZERO;
      def_r  <= 1'b0;
      ack_r  <= 1'b0;
      vld_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], tgl};
      ref_r  <= sync_r[STAGES-1];
      cnt_r  <= cnt_nxt_s;
      def_r  <= def_nxt_s;
      ack_r  <= ack_r ^ ack_flip_s;
      vld_r  <= (cnt_nxt_s != CNT_ZERO);
    end
  end

  assign ack_tgl = ack_r;
  assign vld     = vld_r;

`ifdef MULTI_SYNC_RX_OVF_EN
  logic ovf_r;

  // Sticky violation flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk_b or negedge b_reset_in) begin
    if (!b_reset_in) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = drop_s ^ ovf_clr;
  assign ovf          = 1'b0;
`endif

endmodule

// File: rtl/multi_sync_rx_ack.sv
// Multi-channel toggle receiver top: shared post-reset warm-up and one channel per toggle line.
// Define MULTI_SYNC_RX_OVF_EN to enable the sticky overflow flags.
module multi_sync_rx_ack
  import multi_sync_rx_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 2,
  parameter int ACK_ON_ACCEPT = 0
) (
  input  logic                clk_b,
  input  logic                b_reset_in,
  input  logic [CHANNELS-1:0] b_tgl_in,
  output logic [CHANNELS-1:0] b_ack_tgl_out,
  output logic [CHANNELS-1:0] b_vld_out,
  input  logic [CHANNELS-1:0] b_rdy_in,
  output logic [CHANNELS-1:0] b_ovf_out,
  input  logic [CHANNELS-1:0] b_ovf_clr_in
);

  localparam int STAGES = eff_sync_stages(SYNC_STAGES);
  localparam int WARM_W = warm_cnt_width(STAGES);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(STAGES + 1);

  logic [WARM_W-1:0] warm_cnt_r;
  logic              warm_done_s;

  // Warm-up lets sources that sat at 1 through reset settle without producing events.
  always_ff @(posedge clk_b or negedge b_reset_in) begin
    if (!b_reset_in) begin
      warm_cnt_r <= {WARM_W{1'b0}};
    end else if (warm_cnt_r != WARM_LAST) begin
      warm_cnt_r <= warm_cnt_r + {{(WARM_W-1){1'b0}}, 1'b1};
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end

  assign warm_done_s = (warm_cnt_r == WARM_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    multi_sync_rx_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W),
      .ACK_ON_ACCEPT(ACK_ON_ACCEPT)
    ) u_chan (
      .clk_b     (clk_b),
      .b_reset_in(b_reset_in),
      .warm_done (warm_done_s),
      .tgl       (b_tgl_in[i]),
      .rdy       (b_rdy_in[i]),
      .ovf_clr   (b_ovf_clr_in[i]),
      .ack_tgl   (b_ack_tgl_out[i]),
      .vld       (b_vld_out[i]),
      .ovf       (b_ovf_out[i])
    );
  end

endmodule

// File: doc/multi_sync_rx_ack.md
Name: multi_sync_rx_ack

Overview:
- Parametrised, multi-channel receive-side successor to the toggle-based valid synchroniser.
- Sits in the destination clock domain and takes CHANNELS asynchronous toggle lines from source-domain senders.
- Converts each toggle into a queued event with a valid/ready handshake and returns a per-channel ack toggle to the sender.
- Adds what the single-channel block lacks: configurable sync depth, downstream backpressure, event counting, selectable early/late ack, and a post-reset warm-up that suppresses spurious events.

Parameters:
- CHANNELS, 4, number of independent toggle channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (minimum 2).
- CNT_W, 2, pending-event counter width per channel; M = 2^CNT_W-1 events max.
- ACK_ON_ACCEPT, 0, 0 = ack toggles when the event is consumed downstream; 1 = ack toggles when the event enters the counter.

Ports:
- clk_b  in  1  destination clock; the only clock.
- b_reset_in  in  1  asynchronous active-low reset.
- b_tgl_in  in  CHANNELS  asynchronous source toggles; one edge = one event.
- b_ack_tgl_out  out  CHANNELS  ack toggle back to source, registered.
- b_vld_out  out  CHANNELS  per-channel event pending.
- b_rdy_in  in  CHANNELS  per-channel downstream ready.
- b_ovf_out  out  CHANNELS  sticky protocol-violation flag (see Optional Feature).
- b_ovf_clr_in  in  CHANNELS  clears b_ovf_out per bit.

Behaviour:
- Reset is asynchronous, active-low, and the clock is single. While b_reset_in=0, all sync flops, edge references, counters, deferred flags, b_ack_tgl_out, b_ovf_out and b_vld_out are 0. Reset may assert at any cycle and aborts everything in flight; the source is expected to reset alongside.
- Warm-up: a shared counter runs SYNC_STAGES+1 cycles after reset release. During warm-up each edge reference copies the last sync stage and no events are generated, so a source toggle already at 1 produces no event.
- Event: ev[i] = sync_last[i] XOR ref[i]; ref[i] <= sync_last[i] every cycle.
- Latency: a toggle change is first captured by edge 1. The counter increments at edge SYNC_STAGES+1, and b_vld_out[i] is high after that edge (3 edges for the default).
- b_vld_out[i] = (cnt[i] != 0). Consume = vld & rdy; cnt decrements at that edge.
- Event and consume in the same cycle leave cnt unchanged.
- ACK_ON_ACCEPT=0: b_ack_tgl_out[i] toggles on every consume edge. An event arriving with cnt==M and no consume is a protocol violation: it is dropped and ovf is set.
- ACK_ON_ACCEPT=1:
  - Ack toggles at the edge an event enters cnt.
  - If cnt==M and no consume, the event is stored in the 1-bit deferred[i] and the ack is withheld.
  - The next consume moves the deferred event into cnt (net cnt unchanged), clears deferred and toggles the ack at that edge.
  - An event arriving with deferred set is a violation: it is dropped and ovf is set.
- Channels are fully independent; there is no arbitration.
- cnt never wraps; it saturates by construction of the rules above.

Optional Feature:
- MULTI_SYNC_RX_OVF_EN defined:
  - b_ovf_out[i] sets on a dropped event and stays set until b_ovf_clr_in[i].
  - Set and clear in the same cycle: set wins.
- Not defined: b_ovf_out is tied 0, b_ovf_clr_in is ignored, and dropped events are silent. The counting and deferral logic is identical either way.

Decomposition:
- Package multi_sync_rx_pkg holds:
  - MIN_SYNC_STAGES=2;
  - localparams ACK_LATE=0 and ACK_EARLY=1;
  - a function computing the warm-up counter width from SYNC_STAGES.
- Sub-module multi_sync_rx_chan: one channel (sync chain, ref, cnt, deferred, ack, ovf). The top holds the shared warm-up counter and a generate loop over CHANNELS.

Test Plan:
- Warm-up: hold b_tgl_in=4'b0101 through reset release -> b_vld_out stays 0 for 20 cycles and b_ack_tgl_out=0.
- Latency/late ack (defaults): toggle ch0 once, b_rdy_in=0 -> b_vld_out[0]=1 exactly 3 edges after capture and ack unchanged. Raise rdy -> one consume, vld falls, ack[0]=1 after that edge.
- Backpressure count (ACK_ON_ACCEPT=1, CNT_W=2): toggle ch2 after each ack, rdy=0 -> cnt reaches 3 with 3 acks and the 4th event is deferred with no ack. One consume -> ack toggles, vld stays 1. Drain -> 4 total consumes.
- Simultaneous: ch1 with cnt=1, event and consume on the same edge -> vld stays 1; 1 ack toggle in late mode.
- Overflow (macro on): in early mode, with deferred set, toggle again -> b_ovf_out[2]=1 and the event is dropped. Assert clr together with a new violation -> flag stays 1; clr alone -> 0.
- Reset mid-operation: cnt=2 on ch3 with async reset pulsed mid-cycle -> all outputs 0 immediately and no event after release.
